// File: rtl/otter_if_stage.sv
// rtl/otter_if_stage.sv - OTTER instruction-fetch stage: PC register, imem port 1, registered IF/ID bundle
// Optional feature: OTTER_IF_MISALIGN_EN (raise ID_EXC on misaligned redirect instead of forcing alignment).
module otter_if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IF_STALL,
    input  logic        IF_FLUSH,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_RD,
    input  logic [31:0] IMEM_DOUT,
    output logic [31:0] ID_IR,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_NEXT_PC,
    output logic        ID_VALID,
    output logic        ID_EXC
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        BOOT,
        RUN,
        STALL,
        BUBBLE
`ifdef OTTER_IF_MISALIGN_EN
        ,
        EXC
`endif
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] id_pc, id_pc_next;
    logic [31:0] id_next_pc;
    logic        id_valid, id_valid_next;
    logic [31:0] hold_ir, hold_next;
    logic [31:0] redirect_target;
`ifdef OTTER_IF_MISALIGN_EN
    logic        id_exc, id_exc_next;
`endif

`ifdef OTTER_IF_MISALIGN_EN
    assign redirect_target = REDIRECT_PC;
`else
    assign redirect_target = {REDIRECT_PC[31:2], 2'b00};
`endif

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            id_pc      <= 32'h0;
            id_next_pc <= 32'h4;
            id_valid   <= 1'b0;
            hold_ir    <= 32'h0;
`ifdef OTTER_IF_MISALIGN_EN
            id_exc     <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            id_pc      <= id_pc_next;
            id_next_pc <= id_pc_next + 32'h4;
            id_valid   <= id_valid_next;
            hold_ir    <= hold_next;
`ifdef OTTER_IF_MISALIGN_EN
            id_exc     <= id_exc_next;
`endif
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        id_pc_next    = id_pc;
        id_valid_next = id_valid;
        hold_next     = hold_ir;
        IMEM_RD       = 1'b1;
`ifdef OTTER_IF_MISALIGN_EN
        id_exc_next   = id_exc;
`endif

        // While frozen the read port idles; on the release cycle PC is re-presented
        // so the next sequential word lands exactly when decode resumes.
        case (state)
            STALL:   IMEM_RD = !IF_STALL;
`ifdef OTTER_IF_MISALIGN_EN
            BUBBLE:  IMEM_RD = (pc[1:0] == 2'b00);
            EXC:     IMEM_RD = 1'b0;
`endif
            default: IMEM_RD = 1'b1;
        endcase

        if (IF_FLUSH) begin
            state_next    = BUBBLE;
            pc_next       = redirect_target;
            id_valid_next = 1'b0;
            hold_next     = 32'h0;
`ifdef OTTER_IF_MISALIGN_EN
            id_exc_next   = 1'b0;
`endif
        end else if (IF_STALL && (state == RUN || state == STALL)) begin
            if (state == RUN)
                hold_next = IMEM_DOUT;
            state_next = STALL;
`ifdef OTTER_IF_MISALIGN_EN
        end else if (state == EXC) begin
            state_next = EXC;
        end else if (state == BUBBLE && pc[1:0] != 2'b00) begin
            state_next    = EXC;
            id_pc_next    = pc;
            id_valid_next = 1'b1;
            id_exc_next   = 1'b1;
`endif
        end else begin
            state_next    = RUN;
            pc_next       = pc + 32'h4;
            id_pc_next    = pc;
            id_valid_next = 1'b1;
        end
    end

    always_comb begin
        ID_IR = IMEM_DOUT;
        if (!id_valid)
            ID_IR = NOP;
        else if (state == STALL)
            ID_IR = hold_ir;
`ifdef OTTER_IF_MISALIGN_EN
        else if (id_exc)
            ID_IR = NOP;
`endif
    end

    assign IMEM_ADDR  = pc;
    assign ID_PC      = id_pc;
    assign ID_NEXT_PC = id_next_pc;
    assign ID_VALID   = id_valid;
`ifdef OTTER_IF_MISALIGN_EN
    assign ID_EXC     = id_exc;
`else
    assign ID_EXC     = 1'b0;
`endif

endmodule
